// File: rtl/sargantana_icache_pkg.sv
// Shared I$ refill types, FSM encodings and default line geometry.
package sargantana_icache_pkg;
    localparam int ICACHE_PADDR_W     = 40;
    localparam int ICACHE_LINE_BYTES  = 64;
    localparam int ICACHE_BEAT_BYTES  = 16;
    localparam int ICACHE_N_WAY       = 4;
    localparam int ICACHE_IDX_W       = 6;
    localparam int ICACHE_WAY_W       = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;
    localparam int ICACHE_BEATS       = ICACHE_LINE_BYTES / ICACHE_BEAT_BYTES;
    localparam int ICACHE_BEAT_W      = (ICACHE_BEATS > 1) ? $clog2(ICACHE_BEATS) : 1;

    typedef logic [2:0] refill_state_t;
    localparam refill_state_t RF_IDLE  = 3'd0;
    localparam refill_state_t RF_REQ   = 3'd1;
    localparam refill_state_t RF_WAIT  = 3'd2;
    localparam refill_state_t RF_WRITE = 3'd3;
    localparam refill_state_t RF_DRAIN = 3'd4;

    typedef struct packed {
        logic [ICACHE_PADDR_W-1:0] paddr;
        logic [ICACHE_WAY_W-1:0]   way;
    } l2_fill_req_t;

    typedef struct packed {
        logic                           inv;
        logic [ICACHE_BEAT_W-1:0]       beat;
        logic [8*ICACHE_BEAT_BYTES-1:0] data;
        logic                           err;
        logic [ICACHE_PADDR_W-1:0]      inv_paddr;
    } l2_fill_resp_t;
endpackage

// File: rtl/sargantana_icache_line_buffer.sv
// Beat-indexed line assembly buffer with a per-beat valid mask.
module sargantana_icache_line_buffer
    import sargantana_icache_pkg::*;
#(
    parameter int BEATS = ICACHE_BEATS,
    parameter int BW    = ICACHE_BEAT_W,
    parameter int DW    = 8 * ICACHE_BEAT_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [BW-1:0]     idx_i,
    input  logic [DW-1:0]     data_i,
    output logic [BEATS-1:0]  mask_o,
    output logic              full_o,
    output logic              full_next_o,
    output logic [BEATS*DW-1:0] line_o
);
    logic [BEATS-1:0]    mask_q;
    logic [BEATS-1:0]    hit;
    logic [BEATS*DW-1:0] data_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < BEATS; i++) begin
            hit[i] = we_i && (idx_i == BW'(i));
        end
    end

    // A repeated index just rewrites its slot; the mask bit is already set.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_q | hit;
        end
        for (int i = 0; i < BEATS; i++) begin
            if (hit[i]) data_q[i*DW +: DW] <= data_i;
        end
    end

    assign mask_o      = mask_q;
    assign full_o      = &mask_q;
    assign full_next_o = &(mask_q | hit);
    assign line_o      = data_q;
endmodule

// File: rtl/sargantana_icache_refill_unit.sv
// I$ line-refill engine: one outstanding miss, out-of-order beats, critical-beat forward.
//   state | meaning
//   IDLE  | ready for a miss
//   REQ   | fill request held to L2 until accepted
//   WAIT  | collecting beats, critical beat forwarded as it arrives
//   WRITE | one-cycle line write into the arrays, miss retired
//   DRAIN | killed miss, swallowing the remaining beats
module sargantana_icache_refill_unit
    import sargantana_icache_pkg::*;
#(
    parameter int  PADDR_W    = ICACHE_PADDR_W,
    parameter int  LINE_BYTES = ICACHE_LINE_BYTES,
    parameter int  BEAT_BYTES = ICACHE_BEAT_BYTES,
    parameter int  N_WAY      = ICACHE_N_WAY,
    parameter int  IDX_W      = ICACHE_IDX_W,
    parameter int  TMO_CYC    = 1023,
    localparam int WAY_W      = (N_WAY > 1) ? $clog2(N_WAY) : 1,
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES,
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int TAG_W      = PADDR_W - IDX_W - OFF_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    miss_valid_i,
    output logic                    miss_ready_o,
    input  logic [PADDR_W-1:0]      miss_paddr_i,
    input  logic [WAY_W-1:0]        miss_way_i,
    input  logic                    kill_i,
    output logic                    l2_req_valid_o,
    input  logic                    l2_req_ready_i,
    output logic [PADDR_W-1:0]      l2_req_paddr_o,
    output logic [WAY_W-1:0]        l2_req_way_o,
    input  logic                    l2_resp_valid_i,
    input  logic                    l2_resp_inv_i,
    input  logic [BW-1:0]           l2_resp_beat_i,
    input  logic [8*BEAT_BYTES-1:0] l2_resp_data_i,
    input  logic                    l2_resp_err_i,
    input  logic [PADDR_W-1:0]      l2_inv_paddr_i,
    output logic                    crit_valid_o,
    output logic [8*BEAT_BYTES-1:0] crit_data_o,
    output logic                    line_we_o,
    output logic                    line_valid_o,
    output logic [IDX_W-1:0]        line_idx_o,
    output logic [WAY_W-1:0]        line_way_o,
    output logic [TAG_W-1:0]        line_tag_o,
    output logic [8*LINE_BYTES-1:0] line_data_o,
    output logic                    inv_valid_o,
    output logic [IDX_W-1:0]        inv_idx_o,
    output logic                    xcpt_o,
    output logic                    done_o,
    output logic                    miss_cyc_pmu_o
);
    localparam int BOFF  = $clog2(BEAT_BYTES);
    localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    refill_state_t      state_q, state_d;
    logic [PADDR_W-1:0] paddr_q;
    logic [WAY_W-1:0]   way_q;
    logic               err_q, poison_q, done_q, done_xcpt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               inv_out_q, inv_hold_q;
    logic [IDX_W-1:0]   inv_out_idx_q, inv_hold_idx_q;

    logic               accept, collecting, beat_fire, inv_fire, tmo_hit, inv_line_hit;
    logic [BW-1:0]      crit_beat;
    logic [IDX_W-1:0]   inv_idx_in;
    logic [BEATS-1:0]   buf_mask;
    logic               buf_full, buf_full_next;
    logic               unused_ok;

    assign accept       = (state_q == RF_IDLE) && miss_valid_i && !kill_i;
    assign collecting   = (state_q == RF_WAIT) || (state_q == RF_DRAIN);
    assign beat_fire    = collecting && l2_resp_valid_i && !l2_resp_inv_i;
    assign inv_fire     = l2_resp_valid_i && l2_resp_inv_i;
    assign crit_beat    = BW'(paddr_q[OFF_W-1:0] >> BOFF);
    assign inv_idx_in   = l2_inv_paddr_i[OFF_W +: IDX_W];
    assign inv_line_hit = l2_inv_paddr_i[PADDR_W-1:OFF_W] == paddr_q[PADDR_W-1:OFF_W];
    assign tmo_hit      = (TMO_CYC != 0) && collecting && !beat_fire && (tmo_q == TMO_W'(1));

    sargantana_icache_line_buffer #(
        .BEATS (BEATS),
        .BW    (BW),
        .DW    (8 * BEAT_BYTES)
    ) u_line_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (accept),
        .we_i        (beat_fire),
        .idx_i       (l2_resp_beat_i),
        .data_i      (l2_resp_data_i),
        .mask_o      (buf_mask),
        .full_o      (buf_full),
        .full_next_o (buf_full_next),
        .line_o      (line_data_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RF_IDLE:  if (accept) state_d = RF_REQ;
            RF_REQ: begin
                if (kill_i)              state_d = RF_IDLE;
                else if (l2_req_ready_i) state_d = RF_WAIT;
            end
            // A kill racing the last beat retires like a completed drain.
            RF_WAIT: begin
                if (tmo_hit)            state_d = RF_IDLE;
                else if (kill_i)        state_d = buf_full_next ? RF_IDLE : RF_DRAIN;
                else if (buf_full_next) state_d = RF_WRITE;
            end
            RF_WRITE: state_d = RF_IDLE;
            RF_DRAIN: if (tmo_hit || buf_full_next) state_d = RF_IDLE;
            default:  state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RF_IDLE;
            paddr_q        <= '0;
            way_q          <= '0;
            err_q          <= 1'b0;
            poison_q       <= 1'b0;
            done_q         <= 1'b0;
            done_xcpt_q    <= 1'b0;
            tmo_q          <= '0;
            inv_out_q      <= 1'b0;
            inv_out_idx_q  <= '0;
            inv_hold_q     <= 1'b0;
            inv_hold_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= collecting && (state_d == RF_IDLE);
            done_xcpt_q <= tmo_hit;
            if (accept) begin
                paddr_q  <= miss_paddr_i;
                way_q    <= miss_way_i;
                err_q    <= 1'b0;
                poison_q <= 1'b0;
            end
            if (beat_fire && (state_q == RF_WAIT) && l2_resp_err_i) err_q <= 1'b1;
            if (inv_fire && (state_q == RF_WAIT) && inv_line_hit) poison_q <= 1'b1;
            // Down-counter of consecutive beat-less cycles, reloaded by every beat.
            if ((state_q == RF_REQ) || beat_fire) tmo_q <= TMO_W'(TMO_CYC);
            else if (!collecting)                 tmo_q <= '0;
            else if (tmo_q != '0)                 tmo_q <= tmo_q - TMO_W'(1);
            // An invalidation seen during WRITE slips a cycle; later ones queue behind it.
            if (inv_hold_q) begin
                inv_out_q      <= 1'b1;
                inv_out_idx_q  <= inv_hold_idx_q;
                inv_hold_q     <= inv_fire;
                inv_hold_idx_q <= inv_idx_in;
            end else if (inv_fire && (state_q == RF_WRITE)) begin
                inv_out_q      <= 1'b0;
                inv_hold_q     <= 1'b1;
                inv_hold_idx_q <= inv_idx_in;
            end else begin
                inv_out_q      <= inv_fire;
                inv_out_idx_q  <= inv_idx_in;
            end
        end
    end

    assign miss_ready_o   = (state_q == RF_IDLE);
    assign l2_req_valid_o = (state_q == RF_REQ) && !kill_i;
    assign l2_req_paddr_o = {paddr_q[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign l2_req_way_o   = way_q;
    assign crit_valid_o   = (state_q == RF_WAIT) && beat_fire && !kill_i &&
                            (l2_resp_beat_i == crit_beat);
    assign crit_data_o    = l2_resp_data_i;
    assign line_we_o      = (state_q == RF_WRITE);
    assign line_valid_o   = (state_q == RF_WRITE) && !poison_q && !err_q;
    assign line_idx_o     = paddr_q[OFF_W +: IDX_W];
    assign line_way_o     = way_q;
    assign line_tag_o     = paddr_q[PADDR_W-1:OFF_W+IDX_W];
    assign inv_valid_o    = inv_out_q;
    assign inv_idx_o      = inv_out_idx_q;
    assign done_o         = (state_q == RF_WRITE) || done_q;
    assign xcpt_o         = ((state_q == RF_WRITE) && err_q) || (done_q && done_xcpt_q);
    assign miss_cyc_pmu_o = (state_q != RF_IDLE);

    assign unused_ok = ^{l2_inv_paddr_i[OFF_W-1:0], buf_mask, buf_full};
endmodule
